module_banco_registros: RTL

MODULE_BANCO_REGISTROS -- requirements
Module: module_banco_registros

---
 rtl/module_banco_registros.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/module_banco_registros.sv
// module_banco_registros: multi-port register file with a sequential clear sweep.
//
// A flop-based array of 2^N words of W bits with one write port and NR combinational read
// ports. The FSM has two states:
//   CLEAR - writes zero to one entry per clock, walking a pointer from 0 to 2^N-1.
//   READY - accepts normal writes.
// While CLEAR is active, every read port returns zero and writes are dropped.
//
// Parameters
//   W         data width of each entry
//   N         address width (depth = 2^N)
//   NR        number of read ports (1..4)
//   ZERO_REG  when non-zero, entry 0 always reads as zero and writes to it are ignored
//   BYPASS    when non-zero, a same-cycle write is forwarded to read ports with a matching address
//
// Ports
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-high reset; starts a fresh clear sweep
//   we_i       write enable
//   addr_rd_i  write address
//   data_in_i  write data
//   addr_rs_i  read addresses, port k at [k*N +: N]
//   rs_o       read data, port k at [k*W +: W] (combinational)
//   clr_i      request a full clear sweep (ignored while one is running)
//   busy_o     high while a clear sweep is in progress (registered)
//   wr_drop_o  one-cycle pulse after a write was rejected by a running sweep (registered)
module module_banco_registros #(
  parameter int W        = 32,
  parameter int N        = 5,
  parameter int NR       = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [N-1:0]    addr_rd_i,
  input  logic [W-1:0]    data_in_i,
  input  logic [NR*N-1:0] addr_rs_i,
  output logic [NR*W-1:0] rs_o,
  input  logic            clr_i,
  output logic            busy_o,
  output logic            wr_drop_o
);

  localparam int             DEPTH    = 2 ** N;
  localparam logic [N-1:0]   PTR_LAST = '1;
  localparam bit             HAS_ZERO = (ZERO_REG != 0);
  localparam bit             HAS_BYP  = (BYPASS != 0);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   ptr_q, ptr_d;
  logic           busy_q, busy_d;
  logic           drop_q, drop_d;

  logic           mem_we;
  logic [N-1:0]   mem_waddr;
  logic [W-1:0]   mem_wdata;
  logic [W-1:0]   mem_q [DEPTH];

  // A write to the hardwired zero entry is discarded silently, without a drop pulse.
  logic           wr_ok;
  assign wr_ok = we_i && !(HAS_ZERO && (addr_rd_i == '0));

  // State, sweep pointer and registered status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state logic and the single array write port.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    drop_d    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = '0;
    unique case (state_q)
      CLEAR: begin
        // Sweep owns the write port; user writes are reported and dropped, clr_i is ignored.
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        drop_d    = we_i;
        if (ptr_q == PTR_LAST) begin
          state_d = READY;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + N'(1);
        end
      end
      READY: begin
        // A write coinciding with clr_i lands first; the sweep then overwrites it anyway.
        if (wr_ok) begin
          mem_we    = 1'b1;
          mem_waddr = addr_rd_i;
          mem_wdata = data_in_i;
        end
        if (clr_i) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
    busy_d = (state_d == CLEAR);
  end

  // Storage array; contents are not reset directly, the sweep that follows reset zeroes them.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Combinational read ports. state_q is forced to CLEAR asynchronously by rst_i,
  // so the outputs drop to zero immediately on reset.
  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [N-1:0] ra;
    logic [W-1:0] rd;

    assign ra = addr_rs_i[k*N +: N];

    always_comb begin
      rd = '0;
      if (state_q != READY) begin
        rd = '0;
      end else if (HAS_ZERO && (ra == '0)) begin
        rd = '0;
      end else if (HAS_BYP && we_i && (ra == addr_rd_i)) begin
        rd = data_in_i;
      end else begin
        rd = mem_q[ra];
      end
    end

    assign rs_o[k*W +: W] = rd;
  end

  assign busy_o    = busy_q;
  assign wr_drop_o = drop_q;

endmodule
